div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the DIV/DIVU ALU operations: restoring radix-2 divider with FSM and iteration counter.
//  Sits beside the EX-stage ALU. EX raises div_start when the decoded ALU op is DIV or DIVU.
//  Holds the pipeline via div_stall until the {remainder, quotient} pair is ready for the HI/LO write.
//  Drops an in-flight divide when EX is flushed (div_annul).
// PARAMETERS
//  DATA_W  32  operand width; result width is 2*DATA_W; iteration count = DATA_W
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         asynchronous reset, active high
//  div_start   in   1         EX holds a DIV/DIVU; held high while stalled
//  div_signed  in   1         1 = DIV (signed), 0 = DIVU; sampled on accept
//  div_a       in   DATA_W    dividend (rs); sampled on accept
//  div_b       in   DATA_W    divisor (rt); sampled on accept
//  div_annul   in   1         flush of EX stage; abandons current divide
//  div_stall   out  1         pipeline hold request
//  div_ready   out  1         one-cycle pulse: div_result valid
//  div_result  out  2*DATA_W  {remainder -> HI, quotient -> LO}
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, counter=0, div_ready=0, div_result=0
//   - div_stall=0 (combinational, see below)
//  States: IDLE, BYZERO, ON, END
//  IDLE:
//   - div_start & !div_annul: accept at this edge
//   - div_b==0 -> BYZERO; else -> ON
//   - On accept to ON: latch |a|,|b| (two's-complement abs if div_signed, else raw), latch sign bits, clear counter
//  ON: one iteration per edge on a 2*DATA_W shift reg {R,Q}, initialised {0, |a|}
//   - shift {R,Q} left 1
//   - trial = R - |b|, computed DATA_W+1 bits wide
//   - trial >= 0: R=trial, Q[0]=1
//   - counter increments; after iteration DATA_W (counter==DATA_W-1) -> END
//   - On the same edge, write div_result with sign fix-up (DIV only):
//     - quotient negated if a_sign^b_sign
//     - remainder negated if a_sign
//  BYZERO: -> END next edge; div_result written to 0 (defined, not MIPS-unpredictable)
//  END:
//   - div_ready=1 for this cycle only; div_stall=0 so the pipeline advances
//   - -> IDLE unconditionally; a start seen in IDLE afterwards is a new instruction
//  div_stall = (IDLE & div_start & !div_annul) | ON | BYZERO
//  Latency (accept edge E): ON: ready in cycle after edge E+DATA_W; stall high DATA_W+1 cycles. BYZERO: ready after E+1; stall 2 cycles
//  div_annul in ON or BYZERO:
//   - -> IDLE next edge; no ready pulse; div_result keeps previous value
//   - annul in END: ignored (result already committed)
//  div_annul and div_start together in IDLE: not accepted, stall low
//  div_result holds its value until the next completion or reset; div_ready is not registered-sticky
//  Overflow: signed 0x80000000 / -1 wraps, q=0x80000000, r=0, no trap
//  Operand changes after accept are ignored (latched copies only)
// TESTING
//  1. DIVU 100/7, accept edge E -> ready in cycle after E+32, result {r=2, q=14}; stall high exactly 33 cycles
//  2. DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; DIV 7/-2 -> q=0xFFFFFFFD, r=1
//  3. DIVU 5/0 -> BYZERO path, ready after E+1, result 0, stall 2 cycles
//  4. annul during 10th ON cycle -> IDLE next edge, stall low, no ready; result unchanged; then DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0
//  5. assert rst mid-ON with no clock edge -> ready=0, result=0, stall=0 at once; after release, first start behaves as test 1
//  6. DIV 0x80000000/0xFFFFFFFF then start held through END into a second DIVU 9/3 -> first q=0x80000000, r=0; one IDLE cycle; second q=3, r=0

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring radix-2 divider sequencer for DIV/DIVU beside the EX-stage ALU.
// Stalls the pipeline until {remainder, quotient} is ready for the HI/LO write.
module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     div_a,
  input  logic [DATA_W-1:0]     div_b,
  input  logic                  div_annul,
  output logic                  div_stall,
  output logic                  div_ready,
  output logic [2*DATA_W-1:0]   div_result
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       counter;
  logic [2*DATA_W-1:0] rq;
  logic [DATA_W-1:0]   b_abs;
  logic                q_neg, r_neg;
  logic                accept, last_iter;

  logic [DATA_W-1:0]   a_abs_in, b_abs_in;
  logic [DATA_W:0]     rem_wide;
  logic [DATA_W-1:0]   rem_sub, quo, rem, q_fix, r_fix;
  logic                trial_ok;
  logic [2*DATA_W-1:0] rq_step;

  assign last_iter = (counter == CW'(DATA_W - 1));

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    div_stall  = 1'b0;
    div_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_start && !div_annul) begin
          accept     = 1'b1;
          div_stall  = 1'b1;
          state_next = (div_b == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        div_stall  = 1'b1;
        state_next = div_annul ? S_IDLE : S_END;
      end
      S_ON: begin
        div_stall = 1'b1;
        if (div_annul)      state_next = S_IDLE;
        else if (last_iter) state_next = S_END;
      end
      S_END: begin
        div_ready  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One restoring step; the bit shifted out of R is kept so divisors above 2^(DATA_W-1) still work.
  always_comb begin
    a_abs_in = (div_signed && div_a[DATA_W-1]) ? -div_a : div_a;
    b_abs_in = (div_signed && div_b[DATA_W-1]) ? -div_b : div_b;
    rem_wide = rq[2*DATA_W-1:DATA_W-1];
    trial_ok = (rem_wide >= {1'b0, b_abs});
    rem_sub  = rem_wide[DATA_W-1:0] - b_abs;
    rq_step  = trial_ok ? {rem_sub, rq[DATA_W-2:0], 1'b1} : {rq[2*DATA_W-2:0], 1'b0};
    quo      = rq_step[DATA_W-1:0];
    rem      = rq_step[2*DATA_W-1:DATA_W];
    q_fix    = q_neg ? -quo : quo;
    r_fix    = r_neg ? -rem : rem;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      counter    <= '0;
      rq         <= '0;
      b_abs      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rq      <= {{DATA_W{1'b0}}, a_abs_in};
        b_abs   <= b_abs_in;
        q_neg   <= div_signed && (div_a[DATA_W-1] ^ div_b[DATA_W-1]);
        r_neg   <= div_signed && div_a[DATA_W-1];
        counter <= '0;
      end else if (state == S_ON && !div_annul) begin
        rq      <= rq_step;
        counter <= counter + 1'b1;
        if (last_iter) div_result <= {r_fix, q_fix};
      end else if (state == S_BYZERO && !div_annul) begin
        div_result <= '0;
      end
    end
  end

endmodule
